fpu_op_sched: RTL and testbench
===============================

# fpu_op_sched

Round-robin scheduler that shares one `fadd` and one `fmul` instance between `NREQ` requesters issuing fused subtract-multiply `(a - b) * c` or add-multiply `(a + b) * c` operations on IEEE-754 single-precision operands. It accepts one operation at a time over a valid/ready handshake. It sequences the operation through the adder and then the multiplier, with registered intermediates, and returns the result with the requester ID on a valid/ready response port. It sits between the issue logic and the shared FPU datapath.

## Interface
- `NREQ`, default 2: number of requesters; legal range 2..4.
- `IDW`, default `$clog2(NREQ)`: width of the requester ID. Derived; do not override.

- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in NREQ: bit i set means requester i presents an operation.
- `req_ready` out NREQ: bit i set means requester i's operation is accepted this cycle. One-hot or zero.
- `req_op` in NREQ: per-requester operation select. 0 = `(a-b)*c`, 1 = `(a+b)*c`.
- `req_a` in NREQ*32: operand a for each requester; requester i uses bits [32i+31:32i].
- `req_b` in NREQ*32: operand b for each requester, packed the same way.
- `req_c` in NREQ*32: operand c for each requester, packed the same way.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer accepts the result.
- `rsp_id` out IDW: index of the requester that owns the result.
- `rsp_res` out 32: result.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, ADD, MUL, RESP.
- IDLE:
  - Grant goes to the first requester with `req_valid` set, searching from `rr_ptr` upward modulo NREQ.
  - `req_ready` is driven combinationally to the granted requester only.
  - On the handshake edge the block captures a, b, c, op and id into operand registers and moves to ADD.
- ADD:
  - The `fadd` input is `num1 = a_q`, `num2 = {a_q... }`: precisely, `num2 = {b_q[31] ^ ~op_q, b_q[30:0]}`, so op 0 sign-flips b (subtract) and op 1 passes b unchanged (add).
  - `sum_q` is loaded from the `fadd` output. Next state MUL.
- MUL: `fmul(sum_q, c_q)` is registered into `res_q`. Next state RESP.
- RESP:
  - `rsp_valid` = 1, `rsp_res` = `res_q`, `rsp_id` = `id_q`.
  - `rsp_valid & rsp_ready` returns the FSM to IDLE.
  - Without `rsp_ready`, the FSM holds; `rsp_res` and `rsp_id` stay stable.
- `rr_ptr` is updated on each accepted request to `(granted id + 1) mod NREQ`.
- `req_ready` is 0 in every state other than IDLE. No new request is accepted in the same cycle as a response handshake.
- Requesters hold their operands and `req_valid` stable until they see `req_ready`. Dropping `req_valid` before grant is legal and simply withdraws the request.
- `req_ready` bits for requesters with `req_valid` = 0 are always 0.
- Reset: asynchronous.
  - State goes to IDLE, `rr_ptr` = 0, and all operand, sum and result registers are cleared.
  - `rsp_valid`, `rsp_id`, `rsp_res` and `busy` are all 0 at reset.
  - Reset during ADD, MUL or RESP discards the operation, and no response is ever issued for it.
- Arithmetic and rounding are exactly those of the existing `fadd` and `fmul`. The block performs no special-value handling of its own.

## Timing
- The accept edge counts as E0. State after E0 is ADD, after E1 is MUL, after E2 is RESP.
- `rsp_valid` is first high in the cycle following E2, i.e. 3 cycles after the accept cycle.
- With `rsp_ready` tied high, the minimum issue interval is 4 cycles per operation.
- `req_ready` is combinational from `req_valid`, `rr_ptr` and the state. There is no combinational path from `rsp_ready` to `req_ready`.

## Configuration
- `FPU_OP_SCHED_STATS_EN`:
  - When defined, the block adds output `ops_done` (out, 16). It counts completed response handshakes, saturates at 0xFFFF, and resets to 0.
  - When undefined, the port and the counter are absent and all other behaviour is identical.

## Test plan
- Subtract-multiply:
  - Stimulus: requester 0, op 0, a = 0x40000000 (2.0), b = 0x3F800000 (1.0), c = 0x40400000 (3.0), `rsp_ready` high.
  - Required response: `rsp_res` = 0x40400000 (3.0) and `rsp_id` = 0, with `rsp_valid` 3 cycles after accept.
- Add-multiply:
  - Stimulus: requester 1, op 1, a = b = 0x3F800000, c = 0x3F000000 (0.5).
  - Required response: `rsp_res` = 0x3F800000, `rsp_id` = 1.
- Contention:
  - Stimulus: both requesters hold `req_valid` continuously, starting from reset.
  - Required response: grants go in the order 0, 1, 0, 1, with exactly one `req_ready` bit high at a time and an interval of 4 cycles.
- Backpressure:
  - Stimulus: hold `rsp_ready` low for 5 cycles in RESP.
  - Required response: `rsp_res` and `rsp_id` stay constant, `req_ready` stays 0 and `busy` stays 1. The FSM returns to IDLE one edge after `rsp_ready` rises.
- Reset mid-operation:
  - Stimulus: assert `rst` while the FSM is in MUL.
  - Required response: all outputs are immediately 0. No `rsp_valid` follows. The next request from requester 1 is granted only if requester 0 is idle, because `rr_ptr` is back at 0.
- Stats (with `FPU_OP_SCHED_STATS_EN`):
  - Stimulus: 3 completed operations.
  - Required response: `ops_done` = 3; `ops_done` = 0 after reset.

Source files
------------

// File: rtl/fpu_op_sched.sv
// Round-robin scheduler sharing one fadd and one fmul across NREQ requesters for (a+/-b)*c.
// Optional FPU_OP_SCHED_STATS_EN adds the ops_done completed-response counter.
module fadd (
  input  logic [31:0] num1,
  input  logic [31:0] num2,
  output logic [31:0] result
);
  logic [31:0] big, sml;
  logic [7:0]  ediff;
  logic [23:0] mb, ms, ms_sh;
  logic [24:0] msum, mnorm;
  logic [9:0]  enorm;
  logic [4:0]  lead;

  always_comb begin
    if (num1[30:0] >= num2[30:0]) begin
      big = num1;
      sml = num2;
    end else begin
      big = num2;
      sml = num1;
    end
    ediff = big[30:23] - sml[30:23];
    mb    = (big[30:23] == '0) ? '0 : {1'b1, big[22:0]};
    ms    = (sml[30:23] == '0) ? '0 : {1'b1, sml[22:0]};
    ms_sh = (ediff > 8'd23) ? '0 : (ms >> ediff);
    msum  = (big[31] == sml[31]) ? ({1'b0, mb} + {1'b0, ms_sh}) : ({1'b0, mb} - {1'b0, ms_sh});
    lead  = '0;
    for (int unsigned i = 0; i < 25; i++) begin
      if (msum[i]) lead = 5'(i);
    end
    // lead==24 is a carry out of the add; otherwise renormalise left after cancellation
    if (lead == 5'd24) begin
      mnorm = msum >> 1;
      enorm = {2'b0, big[30:23]} + 10'd1;
    end else begin
      mnorm = msum << (5'd23 - lead);
      enorm = {2'b0, big[30:23]} - {5'b0, 5'd23 - lead};
    end
    if (msum == '0 || enorm[9] || enorm == '0) begin
      result = '0;
    end else if (enorm >= 10'd255) begin
      result = {big[31], 8'hFF, 23'b0};
    end else begin
      result = {big[31], enorm[7:0], mnorm[22:0]};
    end
  end
endmodule

module fmul (
  input  logic [31:0] num1,
  input  logic [31:0] num2,
  output logic [31:0] result
);
  logic [23:0] ma, mb;
  logic [47:0] prod;
  logic [22:0] frac;
  logic [9:0]  e;
  logic        sign;

  always_comb begin
    sign = num1[31] ^ num2[31];
    ma   = (num1[30:23] == '0) ? '0 : {1'b1, num1[22:0]};
    mb   = (num2[30:23] == '0) ? '0 : {1'b1, num2[22:0]};
    prod = ma * mb;
    if (prod[47]) begin
      frac = prod[46:24];
      e    = {2'b0, num1[30:23]} + {2'b0, num2[30:23]} - 10'd126;
    end else begin
      frac = prod[45:23];
      e    = {2'b0, num1[30:23]} + {2'b0, num2[30:23]} - 10'd127;
    end
    if (ma == '0 || mb == '0 || e[9] || e == '0) begin
      result = {sign, 31'b0};
    end else if (e >= 10'd255) begin
      result = {sign, 8'hFF, 23'b0};
    end else begin
      result = {sign, e[7:0], frac};
    end
  end
endmodule

module fpu_op_sched #(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ-1:0]    req_op,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  input  logic [NREQ*32-1:0] req_c,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [31:0]        rsp_res,
  output logic               busy
`ifdef FPU_OP_SCHED_STATS_EN
  ,
  output logic [15:0]        ops_done
`endif
);
  typedef enum logic [1:0] {IDLE, ADD, MUL, RESP} state_t;

  state_t          state;
  logic [IDW-1:0]  rr_ptr, gnt_id, id_q;
  logic            gnt_any, op_q, sel_op;
  logic [31:0]     a_q, b_q, c_q, sum_q, res_q;
  logic [31:0]     sel_a, sel_b, sel_c, add_res, mul_res;
  int unsigned     idx;

  // Rotating priority search starting at rr_ptr
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(rr_ptr) + k) % NREQ;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = IDW'(idx);
      end
    end
    sel_a  = '0;
    sel_b  = '0;
    sel_c  = '0;
    sel_op = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IDW'(i) == gnt_id) begin
        sel_a  = req_a[i*32 +: 32];
        sel_b  = req_b[i*32 +: 32];
        sel_c  = req_c[i*32 +: 32];
        sel_op = req_op[i];
      end
    end
    req_ready = (state == IDLE && gnt_any) ? ({{(NREQ-1){1'b0}}, 1'b1} << gnt_id) : '0;
  end

  fadd u_fadd (
    .num1   (a_q),
    .num2   ({b_q[31] ^ ~op_q, b_q[30:0]}),
    .result (add_res)
  );

  fmul u_fmul (
    .num1   (sum_q),
    .num2   (c_q),
    .result (mul_res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      id_q   <= '0;
      op_q   <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      sum_q  <= '0;
      res_q  <= '0;
    end else begin
      case (state)
        IDLE: if (gnt_any) begin
          a_q    <= sel_a;
          b_q    <= sel_b;
          c_q    <= sel_c;
          op_q   <= sel_op;
          id_q   <= gnt_id;
          rr_ptr <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
          state  <= ADD;
        end
        ADD: begin
          sum_q <= add_res;
          state <= MUL;
        end
        MUL: begin
          res_q <= mul_res;
          state <= RESP;
        end
        RESP: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  assign rsp_id    = id_q;
  assign rsp_res   = res_q;

`ifdef FPU_OP_SCHED_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops_done <= '0;
    end else if (state == RESP && rsp_ready && ops_done != 16'hFFFF) begin
      ops_done <= ops_done + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fpu_op_sched.sv
// Scoreboard bench for fpu_op_sched: directed vectors, queue of expected responses, separate monitor.
module tb_fpu_op_sched;
  localparam int NREQ = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req_valid, req_ready, req_op;
  logic [NREQ*32-1:0] req_a, req_b, req_c;
  logic            rsp_valid, rsp_ready, busy;
  logic [0:0]      rsp_id;
  logic [31:0]     rsp_res;
`ifdef FPU_OP_SCHED_STATS_EN
  logic [15:0]     ops_done;
`endif

  fpu_op_sched #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_c     (req_c),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_res   (rsp_res),
    .busy      (busy)
`ifdef FPU_OP_SCHED_STATS_EN
    ,
    .ops_done  (ops_done)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [0:0]  id;
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_res [NREQ];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          last_gnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got timeout/unexpected event expected none (cycle %0d)", name, cyc);
  endtask

  task automatic set_req(input int i, input logic op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] res);
    req_op[i]          = op;
    req_a[i*32 +: 32]  = a;
    req_b[i*32 +: 32]  = b;
    req_c[i*32 +: 32]  = c;
    exp_res[i]         = res;
  endtask

  // Present vmask, expect exp_gnt granted; gap>0 also checks distance from the previous grant.
  task automatic arb(input logic [1:0] vmask, input logic [1:0] exp_gnt, input int gap, input bit keep);
    int idn;
    bit got;
    got = 1'b0;
    req_valid = vmask;
    idn = exp_gnt[1] ? 1 : 0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (req_ready != '0) got = 1'b1;
    end
    if (!got) begin
      fail_now("grant_timeout");
    end else begin
      chk("grant", 32'(req_ready), 32'(exp_gnt));
      if (gap > 0) chk("grant_gap", cyc - last_gnt, gap);
      last_gnt = cyc;
      exp_q.push_back('{idn[0:0], exp_res[idn], cyc});
    end
    @(posedge clk); #1;
    if (!keep) req_valid = '0;
  endtask

  task automatic drain();
    for (int t = 0; t < 40 && exp_q.size() != 0; t++) @(negedge clk);
    if (exp_q.size() != 0) fail_now("drain_timeout");
    @(posedge clk); #1;
  endtask

  // Monitor: checks every response against the scoreboard head, plus hold stability under backpressure
  bit          seen = 1'b0;
  bit          held = 1'b0;
  logic [0:0]  hid;
  logic [31:0] hres;

  always @(negedge clk) begin
    if (rst) begin
      seen = 1'b0;
      held = 1'b0;
    end else begin
      if (req_ready != '0) begin
        chk("ready_onehot", 32'($onehot(req_ready)), 32'd1);
        chk("ready_without_valid", 32'(req_ready & ~req_valid), 32'd0);
      end
      if (held) begin
        chk("bp_valid", 32'(rsp_valid), 32'd1);
        chk("bp_id", 32'(rsp_id), 32'(hid));
        chk("bp_res", rsp_res, hres);
        chk("bp_busy", 32'(busy), 32'd1);
        chk("bp_req_ready", 32'(req_ready), 32'd0);
      end
      held = rsp_valid && !rsp_ready;
      hid  = rsp_id;
      hres = rsp_res;
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_rsp");
        end else begin
          if (!seen) chk("latency", cyc, exp_q[0].cyc + 3);
          seen = 1'b1;
          if (rsp_ready) begin
            chk("rsp_id", 32'(rsp_id), 32'(exp_q[0].id));
            chk("rsp_res", rsp_res, exp_q[0].res);
            void'(exp_q.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    int vcnt;
    bit got;
    rst       = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    req_c     = '0;
    rsp_ready = 1'b1;
    // (3-1)*2 = 4 ; (1.5+0.5)*1.5 = 3
    set_req(0, 1'b0, 32'h40400000, 32'h3F800000, 32'h40000000, 32'h40800000);
    set_req(1, 1'b1, 32'h3FC00000, 32'h3F000000, 32'h3FC00000, 32'h40400000);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_res", rsp_res, 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);

    // Contention straight out of reset
    req_valid = 2'b11;
    @(posedge clk); #1;
    rst = 1'b0;
    arb(2'b11, 2'b01, 0, 1'b1);
    arb(2'b11, 2'b10, 4, 1'b1);
    arb(2'b11, 2'b01, 4, 1'b1);
    arb(2'b11, 2'b10, 4, 1'b0);
    drain();

    // Subtract-multiply: (2-1)*3 = 3
    set_req(0, 1'b0, 32'h40000000, 32'h3F800000, 32'h40400000, 32'h40400000);
    arb(2'b01, 2'b01, 0, 1'b0);
    drain();
    // Add-multiply: (1+1)*0.5 = 1
    set_req(1, 1'b1, 32'h3F800000, 32'h3F800000, 32'h3F000000, 32'h3F800000);
    arb(2'b10, 2'b10, 0, 1'b0);
    drain();

    // Backpressure for 5 cycles in RESP
    rsp_ready = 1'b0;
    arb(2'b01, 2'b01, 0, 1'b0);
    got = 1'b0;
    for (int t = 0; t < 10 && !got; t++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    if (!got) fail_now("bp_rsp_timeout");
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_after_ready", 32'(busy), 32'd0);

    // Reset while in MUL; rr_ptr is 1 before the reset
    arb(2'b01, 2'b01, 0, 1'b0);
    @(posedge clk); #1;
    chk("mul_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("mid_rst_rsp_res", rsp_res, 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
`ifdef FPU_OP_SCHED_STATS_EN
    chk("stats_rst", 32'(ops_done), 32'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    vcnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) vcnt++;
    end
    chk("no_rsp_after_rst", vcnt, 0);
    @(posedge clk); #1;
    arb(2'b11, 2'b01, 0, 1'b0);
    drain();
    arb(2'b10, 2'b10, 0, 1'b0);
    drain();
    arb(2'b01, 2'b01, 0, 1'b0);
    drain();
`ifdef FPU_OP_SCHED_STATS_EN
    chk("stats_ops_done", 32'(ops_done), 32'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion expected $finish");
    $fatal(1, "timeout");
  end
endmodule
